enc32to5_rr: RTL and testbench
==============================

// Module: enc32to5_rr
// PURPOSE
//  Sequential 32-to-5 round-robin encoder: the encode side of the 5-to-32 write-enable decoder.
//  Collects one-hot/multi-hot event pulses per register (e.g. writeback-complete, scoreboard
//  release) into a sticky pending vector. Offers one 5-bit register index at a time on a
//  valid/ready handshake. Feeds the multicycle control FSM and the register-status logic.
// PARAMETERS
//  W          32  number of request lines (power of 2)
//  IDXW       5   index width, = log2(W)
//  MASK_ZERO  1   1: line 0 ($zero) never becomes pending; 0: line 0 treated like the others
// PORTS
//  clk        in   1     rising-edge clock
//  reset_n    in   1     asynchronous active-low reset
//  req        in   W     event pulses, one bit per register, sampled every edge
//  flush      in   1     synchronous clear of pending, offer and pointer
//  ready      in   1     consumer accepts idx this cycle
//  valid      out  1     idx is valid and held stable until accepted
//  idx        out  IDXW  offered register index
//  busy       out  1     |pending (registered vector, excludes offered bit once cleared)
//  overrun    out  1     sticky; present only with ENC_OVERRUN_EN
// BEHAVIOUR
//  - Reset (async, reset_n=0): pending=0, valid=0, idx=0, ptr=0, overrun=0; no clock needed.
//  - pending[i] next = (pending[i] & ~clr[i]) | req[i]; clr[i]=valid&ready&(idx==i).
//    Same-cycle req[i] and clr[i]: req wins, bit stays pending (new event, offered again).
//  - MASK_ZERO=1: req[0] ignored; pending[0] is constant 0.
//  - Pick: first set bit of pending scanning ptr, ptr+1, ..., W-1, 0, ..., ptr-1 (mod W).
//  - FSM, 2 states:
//    IDLE  (valid=0): if pick found -> load idx, go OFFER.
//    OFFER (valid=1): idx and valid held constant while ready=0, regardless of new req.
//      On ready=1: ptr <= idx+1 (31 -> 0 wrap). Pick over pending&~clr from the new ptr.
//      If a pick is found -> load idx, stay OFFER (back-to-back). Otherwise go IDLE.
//  - Latency: req bit at edge E -> pending after E -> valid=1 after E+1 (2 edges).
//  - Throughput: one index per cycle with ready held high.
//  - flush=1: pending<=0, valid<=0, ptr<=0, state<=IDLE. req in the same cycle is dropped.
//    flush overrides ready.
//  - reset_n asserted mid-OFFER: offer abandoned immediately; no accept is implied.
//  - busy is combinational OR of the pending register only.
// CONFIGURATION
//  ENC_OVERRUN_EN defined: overrun port exists.
//    overrun <= 1 when req[i]=1 while pending[i]=1 and clr[i]=0 (event lost).
//    Sticky until reset_n or flush.
//  ENC_OVERRUN_EN undefined: no overrun port and no logic; all other behaviour is identical.
// STRUCTURE
//  - Shared package: ENC_W=32, ENC_IDXW=5, FSM state encodings ENC_IDLE=1'b0, ENC_OFFER=1'b1.
//  - Sub-module rr_pick32: combinational. Inputs pending[W], ptr[IDXW];
//    outputs found, pick[IDXW]. Uses a rotate, fixed-priority encode, un-rotate.
//    Instantiated once, fed by the mux pending vs pending&~clr.
//  - Top level: pending register, ptr register, FSM, idx/valid registers, optional overrun.
// TESTING
//  1. reset_n=0 mid-stream with req=FFFFFFFF -> valid=0, idx=0, busy=0 asynchronously.
//     Hold 0 after release with req=0.
//  2. Single req=32'h00000010 pulse, ready=0 -> valid=1, idx=4 two edges later.
//     Held 5 cycles. ready=1 one cycle -> valid=0 next cycle, busy=0.
//  3. req=32'h80000006 pulse after reset, ready held 1 -> idx 1, 2, 31 on consecutive cycles.
//     Then valid=0; ptr wrapped to 0.
//  4. req[3] pulsed every cycle, req[5] pulsed once, ready=1 -> grant order 3, 5, 3, 3, ...
//     Bit 5 is never starved.
//  5. MASK_ZERO=1, req=32'h00000001 -> valid never asserts, busy=0.
//     Same-cycle req[9] with accept of idx 9 -> idx 9 offered again.
//  6. With ENC_OVERRUN_EN: req[7] twice, ready=0 -> overrun=1 and stays 1.
//     flush=1 -> overrun=0, valid=0, busy=0.

Source files
------------

// File: rtl/enc32to5_rr_pkg.sv
// Shared definitions for the 32-to-5 round-robin encoder.
//   ENC_W       number of request lines
//   ENC_IDXW    width of the offered register index
//   enc_state_e offer FSM states (IDLE: nothing offered, OFFER: idx/valid held)
package enc32to5_rr_pkg;

  localparam int ENC_W    = 32;
  localparam int ENC_IDXW = 5;

  typedef enum logic {
    ENC_IDLE  = 1'b0,
    ENC_OFFER = 1'b1
  } enc_state_e;

endpackage

// File: rtl/enc32to5_rr_if.sv
// Event/offer bundle between the encoder and its environment.
//   req      event pulses, one bit per register
//   flush    synchronous clear of pending vector, offer and pointer
//   ready    consumer accepts idx this cycle
//   valid    idx is valid and held stable until accepted
//   idx      offered register index
//   busy     OR of the pending vector
//   overrun  sticky lost-event flag (only when ENC_OVERRUN_EN is defined)
// modport master: the encoder (drives the offer); modport slave: the consumer.
interface enc32to5_rr_if
  import enc32to5_rr_pkg::*;
#(
  parameter int W    = ENC_W,
  parameter int IDXW = ENC_IDXW
) ();

  logic [W-1:0]    req;
  logic            flush;
  logic            ready;
  logic            valid;
  logic [IDXW-1:0] idx;
  logic            busy;
`ifdef ENC_OVERRUN_EN
  logic            overrun;
`endif

  modport master (
    input  req, flush, ready,
    output valid, idx, busy
`ifdef ENC_OVERRUN_EN
    , output overrun
`endif
  );

  modport slave (
    output req, flush, ready,
    input  valid, idx, busy
`ifdef ENC_OVERRUN_EN
    , input overrun
`endif
  );

endinterface

// File: rtl/enc32to5_rr_rr_pick32.sv
// rr_pick32: combinational round-robin picker.
//   pending  candidate vector
//   ptr      index where the scan starts (wraps modulo W)
//   found    at least one candidate bit is set
//   pick     first set bit at or after ptr, wrapping
// The vector is rotated so that bit ptr lands at position 0, a fixed-priority
// encoder finds the lowest set bit, and adding ptr back un-rotates the result
// (the add wraps naturally in IDXW bits because W is a power of two).
module rr_pick32
  import enc32to5_rr_pkg::*;
#(
  parameter int W    = ENC_W,
  parameter int IDXW = ENC_IDXW
) (
  input  logic [W-1:0]    pending,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] pick
);

  logic [2*W-1:0]  dbl;
  logic [W-1:0]    rot;
  logic [IDXW-1:0] pos;

  assign dbl = {pending, pending};
  assign rot = W'(dbl >> ptr);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    pos   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        pos   = IDXW'(i);
      end
    end
  end

  assign pick = ptr + pos;

endmodule

// File: rtl/enc32to5_rr.sv
// enc32to5_rr: sequential 32-to-5 round-robin encoder.
// Collects per-register event pulses into a sticky pending vector and offers
// one register index at a time on a valid/ready handshake.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      enc32to5_rr_if.master (req, flush, ready, valid, idx, busy[, overrun])
// Optional feature macro: ENC_OVERRUN_EN adds the sticky overrun output.
module enc32to5_rr
  import enc32to5_rr_pkg::*;
#(
  parameter int W         = ENC_W,
  parameter int IDXW      = ENC_IDXW,
  parameter bit MASK_ZERO = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  enc32to5_rr_if.master  bus
);

  enc_state_e      state_reg;
  logic [W-1:0]    pending_reg;
  logic [IDXW-1:0] ptr_reg;
  logic [IDXW-1:0] idx_reg;

  logic [W-1:0]    req_eff;
  logic [W-1:0]    clr;
  logic [W-1:0]    pending_kept;
  logic [W-1:0]    pending_next;
  logic [W-1:0]    pick_vec;
  logic [IDXW-1:0] pick_ptr;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] idx_inc;
  logic            pick_found;
  logic            accept;

  assign accept  = (state_reg == ENC_OFFER) & bus.ready;
  assign idx_inc = idx_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_line
      // Line 0 is the hardwired zero register when MASK_ZERO is set.
      if (gi == 0) begin : g_zero
        assign req_eff[gi] = bus.req[gi] & ~MASK_ZERO;
      end else begin : g_other
        assign req_eff[gi] = bus.req[gi];
      end
      assign clr[gi] = accept & (idx_reg == IDXW'(gi));
    end
  endgenerate

  // A new event on the line being accepted re-arms it (req wins over clr).
  assign pending_kept = pending_reg & ~clr;
  assign pending_next = pending_kept | req_eff;

  // On accept the next pick must skip the bit just granted and start after it.
  assign pick_vec = accept ? pending_kept : pending_reg;
  assign pick_ptr = accept ? idx_inc : ptr_reg;

  rr_pick32 #(
    .W    (W),
    .IDXW (IDXW)
  ) u_pick (
    .pending (pick_vec),
    .ptr     (pick_ptr),
    .found   (pick_found),
    .pick    (pick_idx)
  );

`ifdef ENC_OVERRUN_EN
  logic overrun_reg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ENC_IDLE;
      pending_reg <= '0;
      ptr_reg     <= '0;
      idx_reg     <= '0;
`ifdef ENC_OVERRUN_EN
      overrun_reg <= 1'b0;
`endif
    end else if (bus.flush) begin
      // flush drops same-cycle req and overrides any accept
      state_reg   <= ENC_IDLE;
      pending_reg <= '0;
      ptr_reg     <= '0;
      idx_reg     <= '0;
`ifdef ENC_OVERRUN_EN
      overrun_reg <= 1'b0;
`endif
    end else begin
      pending_reg <= pending_next;
`ifdef ENC_OVERRUN_EN
      if (|(req_eff & pending_kept)) begin
        overrun_reg <= 1'b1;
      end
`endif
      case (state_reg)
        ENC_IDLE: begin
          if (pick_found) begin
            idx_reg   <= pick_idx;
            state_reg <= ENC_OFFER;
          end
        end
        ENC_OFFER: begin
          if (bus.ready) begin
            ptr_reg <= idx_inc;
            if (pick_found) begin
              idx_reg <= pick_idx;
            end else begin
              state_reg <= ENC_IDLE;
            end
          end
        end
        default: state_reg <= ENC_IDLE;
      endcase
    end
  end

  assign bus.valid = (state_reg == ENC_OFFER);
  assign bus.idx   = idx_reg;
  assign bus.busy  = |pending_reg;
`ifdef ENC_OVERRUN_EN
  assign bus.overrun = overrun_reg;
`endif

endmodule

// File: tb/tb_enc32to5_rr.sv
// Testbench for enc32to5_rr: directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a behavioural model.
module tb_enc32to5_rr;
  import enc32to5_rr_pkg::*;

  localparam bit MASK_ZERO = 1'b1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  enc32to5_rr_if #(.W(ENC_W), .IDXW(ENC_IDXW)) bus ();

  enc32to5_rr #(.W(ENC_W), .IDXW(ENC_IDXW), .MASK_ZERO(MASK_ZERO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pend;
  bit          m_valid;
  int          m_idx;
  int          m_ptr;
  bit          m_ovr;

  function automatic int find_from(input logic [31:0] v, input int start);
    for (int k = 0; k < 32; k++) begin
      int j;
      j = (start + k) % 32;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_valid = 0; m_idx = 0; m_ptr = 0; m_ovr = 0;
  endtask

  task automatic model_step(input logic [31:0] r, input logic f, input logic rd);
    logic [31:0] req_e, kept;
    int j;
    if (f) begin
      model_reset();
      return;
    end
    req_e = r;
    if (MASK_ZERO) req_e[0] = 1'b0;
    kept = m_pend;
    if (m_valid && rd) kept[m_idx] = 1'b0;
    if ((req_e & kept) != 0) m_ovr = 1;
    if (!m_valid) begin
      j = find_from(m_pend, m_ptr);
      if (j >= 0) begin m_valid = 1; m_idx = j; end
    end else if (rd) begin
      m_ptr = (m_idx + 1) % 32;
      j = find_from(kept, m_ptr);
      if (j >= 0) m_idx = j;
      else m_valid = 0;
    end
    m_pend = kept | req_e;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [31:0] r, input logic f, input logic rd);
    bus.req = r; bus.flush = f; bus.ready = rd;
    @(posedge clk);
    model_step(r, f, rd);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.flush = 1'b0; bus.ready = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(32'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] req;
    logic        rd;
    logic        ev;
    logic [4:0]  ei;
    logic        eb;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int grants[$];
    int exp4[5];
    int n5;
    bit saw_valid, saw_busy;

    // outputs expected after the edge at which the row's inputs are applied
    tbl[0]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 5'd0,  1'b1};
    tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd4,  1'b1};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd4,  1'b1};
    tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd4,  1'b1};
    tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd4,  1'b1};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd4,  1'b1};
    tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  1'b0};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b0, 5'd0,  1'b0};
    tbl[8]  = '{1'b1, 32'h8000_0006, 1'b1, 1'b0, 5'd0,  1'b1};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd1,  1'b1};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd2,  1'b1};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 5'd31, 1'b1};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b0, 5'd0,  1'b0};
    tbl[13] = '{1'b0, 32'h4000_0002, 1'b0, 1'b0, 5'd0,  1'b1};
    tbl[14] = '{1'b0, 32'h0,         1'b0, 1'b1, 5'd1,  1'b1};

    bus.req = '0; bus.flush = 1'b0; bus.ready = 1'b0;

    // ---- 1: asynchronous reset mid-offer ----
    do_reset();
    chk("reset_valid", {31'b0, bus.valid}, 32'd0);
    chk("reset_busy",  {31'b0, bus.busy},  32'd0);
    step(32'hFFFF_FFFF, 1'b0, 1'b0);
    step(32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("pre_reset_valid", {31'b0, bus.valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid", {31'b0, bus.valid}, 32'd0);
    chk("async_idx",   {27'b0, bus.idx},   32'd0);
    chk("async_busy",  {31'b0, bus.busy},  32'd0);
    repeat (2) @(negedge clk);
    chk("in_reset_busy", {31'b0, bus.busy}, 32'd0);
    bus.req = '0;
    reset_n = 1'b1;
    saw_valid = 0; saw_busy = 0;
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b0);
      saw_valid |= bus.valid; saw_busy |= bus.busy;
    end
    chk("post_reset_valid", {31'b0, saw_valid}, 32'd0);
    chk("post_reset_busy",  {31'b0, saw_busy},  32'd0);

    // ---- 2 and 3: vector table ----
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].req, 1'b0, tbl[i].rd);
      chk($sformatf("tbl%0d_valid", i), {31'b0, bus.valid}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_busy", i),  {31'b0, bus.busy},  {31'b0, tbl[i].eb});
      if (tbl[i].ev) chk($sformatf("tbl%0d_idx", i), {27'b0, bus.idx}, {27'b0, tbl[i].ei});
    end

    // ---- 4: fairness with a hot line ----
    do_reset();
    exp4 = '{3, 5, 3, 3, 3};
    step(32'h0000_0028, 1'b0, 1'b1);
    if (bus.valid) grants.push_back(int'(bus.idx));
    for (int i = 0; i < 10; i++) begin
      step(32'h0000_0008, 1'b0, 1'b1);
      if (bus.valid) grants.push_back(int'(bus.idx));
    end
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_grant%0d", k), (k < grants.size()) ? grants[k] : 99, exp4[k]);
    n5 = 0;
    foreach (grants[k]) if (grants[k] == 5) n5++;
    chk("rr_grant5_count", n5, 1);

    // ---- 5: masked line 0 and re-arm on accept ----
    do_reset();
    saw_valid = 0; saw_busy = 0;
    step(32'h0000_0001, 1'b0, 1'b0);
    saw_valid |= bus.valid; saw_busy |= bus.busy;
    for (int i = 0; i < 3; i++) begin
      step(32'h0, 1'b0, 1'b0);
      saw_valid |= bus.valid; saw_busy |= bus.busy;
    end
    chk("mask0_valid", {31'b0, saw_valid}, 32'd0);
    chk("mask0_busy",  {31'b0, saw_busy},  32'd0);
    step(32'h0000_0200, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("rearm_offer_idx", {27'b0, bus.idx}, 32'd9);
    step(32'h0000_0200, 1'b0, 1'b1);
    chk("rearm_busy", {31'b0, bus.busy}, 32'd1);
    step(32'h0, 1'b0, 1'b0);
    chk("rearm_valid", {31'b0, bus.valid}, 32'd1);
    chk("rearm_idx",   {27'b0, bus.idx},   32'd9);

    // ---- 6: overrun and flush ----
    do_reset();
    step(32'h0000_0080, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0000_0080, 1'b0, 1'b0);
`ifdef ENC_OVERRUN_EN
    chk("overrun_set", {31'b0, bus.overrun}, 32'd1);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("overrun_sticky", {31'b0, bus.overrun}, 32'd1);
`endif
    step(32'h0000_0100, 1'b1, 1'b1);
    chk("flush_valid", {31'b0, bus.valid}, 32'd0);
    chk("flush_busy",  {31'b0, bus.busy},  32'd0);
`ifdef ENC_OVERRUN_EN
    chk("flush_overrun", {31'b0, bus.overrun}, 32'd0);
`endif

    // ---- randomized run against the model ----
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] r;
      logic rd, f;
      r  = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      rd = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 63) == 0);
      step(r, f, rd);
      chk($sformatf("rnd%0d_valid", c), {31'b0, bus.valid}, {31'b0, m_valid});
      chk($sformatf("rnd%0d_busy", c),  {31'b0, bus.busy},  {31'b0, (m_pend != 0)});
      if (m_valid) chk($sformatf("rnd%0d_idx", c), {27'b0, bus.idx}, m_idx);
`ifdef ENC_OVERRUN_EN
      chk($sformatf("rnd%0d_overrun", c), {31'b0, bus.overrun}, {31'b0, m_ovr});
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
